// File: rtl/w5300_bus_arbiter.sv
// w5300_bus_arbiter: round-robin arbiter sharing the single W5300 parallel-IF
// command port among N_REQ requesters. It issues one register access at a time,
// supports a per-requester bus lock for bursts, and aborts an access that runs
// too long.
// Optional build macro W5300_ARB_INT_PRIO_EN: requester 0 (interrupt service)
// wins every idle arbitration. It may pre-empt a locked owner between accesses;
// the locked owner keeps its sticky status and gets the bus back afterwards.
module w5300_bus_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      lock,
    input  logic [12*N_REQ-1:0]   req_caddr,
    input  logic [16*N_REQ-1:0]   req_wr_data,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic [15:0]           rd_data_out,
    output logic                  arb_busy,
    output logic [11:0]           caddr,
    output logic [15:0]           wr_data,
    input  logic                  op_status,
    input  logic [15:0]           rd_data
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [11:0] CADDR_NONE = 12'h800;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
    state_t state_reg, state_next;

    // Unpacked per-requester views of the packed command buses
    logic [10:0]      cmd_arr  [N_REQ];
    logic [15:0]      wdat_arr [N_REQ];
    logic [N_REQ-1:0] unused_cmd_bit11;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign cmd_arr[gi]          = req_caddr[12*gi +: 11];
            assign unused_cmd_bit11[gi] = req_caddr[12*gi + 11];
            assign wdat_arr[gi]         = req_wr_data[16*gi +: 16];
        end
    endgenerate

    logic [IDX_W-1:0]     owner_reg;
    logic [IDX_W-1:0]     ptr_reg;
    logic [IDX_W-1:0]     sticky_owner_reg;
    logic                 sticky_valid_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 timeout_reg;
    logic                 cmd_read_reg;
    logic [11:0]          caddr_reg;
    logic [15:0]          wr_data_reg;
    logic [15:0]          rd_data_reg;

    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic             sticky_hit;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic             timeout_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Winner selection and next-state logic
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_reg;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rr_found && req[IDX_W'((int'(ptr_reg) + k) % N_REQ)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'((int'(ptr_reg) + k) % N_REQ);
            end
        end
        sticky_hit = sticky_valid_reg && lock[sticky_owner_reg] && req[sticky_owner_reg];
        win_valid  = 1'b0;
        win_idx    = rr_idx;
`ifdef W5300_ARB_INT_PRIO_EN
        if (req[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
        end else
`endif
        if (sticky_hit) begin
            win_valid = 1'b1;
            win_idx   = sticky_owner_reg;
        end else if (rr_found) begin
            win_valid = 1'b1;
            win_idx   = rr_idx;
        end
        timeout_hit = (cnt_reg == CNT_LAST);
        state_next  = state_reg;
        case (state_reg)
            IDLE:  if (win_valid && !op_status) state_next = ISSUE;
            ISSUE: if (timeout_hit) state_next = DONE;
                   else if (op_status) state_next = BUSY;
            BUSY:  if (!op_status || timeout_hit) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: command latch, timeout counter, read capture, pointer and lock owner
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg        <= '0;
            ptr_reg          <= '0;
            sticky_owner_reg <= '0;
            sticky_valid_reg <= 1'b0;
            cnt_reg          <= '0;
            timeout_reg      <= 1'b0;
            cmd_read_reg     <= 1'b0;
            caddr_reg        <= CADDR_NONE;
            wr_data_reg      <= '0;
            rd_data_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A lock owner that stopped requesting (or dropped lock) gives up the bus
                    if (sticky_valid_reg && !(lock[sticky_owner_reg] && req[sticky_owner_reg]))
                        sticky_valid_reg <= 1'b0;
                    if (state_next == ISSUE) begin
                        owner_reg    <= win_idx;
                        caddr_reg    <= {1'b0, cmd_arr[win_idx]};
                        wr_data_reg  <= wdat_arr[win_idx];
                        cmd_read_reg <= cmd_arr[win_idx][10];
                        cnt_reg      <= '0;
                        timeout_reg  <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (timeout_hit) begin
                        caddr_reg   <= CADDR_NONE;
                        timeout_reg <= 1'b1;
                        rd_data_reg <= 16'hFFFF;
                    end else if (op_status) begin
                        // Command accepted; withdraw it so the IF cannot start twice
                        caddr_reg <= CADDR_NONE;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (!op_status) begin
                        if (cmd_read_reg) rd_data_reg <= rd_data;
                    end else if (timeout_hit) begin
                        caddr_reg   <= CADDR_NONE;
                        timeout_reg <= 1'b1;
                        rd_data_reg <= 16'hFFFF;
                    end
                end
                DONE: begin
                    if (lock[owner_reg] && !timeout_reg) begin
                        sticky_owner_reg <= owner_reg;
                        sticky_valid_reg <= 1'b1;
                    end else begin
                        ptr_reg <= (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
                        if (sticky_owner_reg == owner_reg) sticky_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from state and owner
    always_comb begin
        grant    = '0;
        done     = '0;
        err      = '0;
        arb_busy = 1'b0;
        case (state_reg)
            IDLE: if (sticky_valid_reg) grant[sticky_owner_reg] = 1'b1;
            ISSUE, BUSY: begin
                grant[owner_reg] = 1'b1;
                arb_busy         = 1'b1;
            end
            DONE: begin
                grant[owner_reg] = 1'b1;
                done[owner_reg]  = 1'b1;
                err[owner_reg]   = timeout_reg;
            end
            default: ;
        endcase
        caddr       = caddr_reg;
        wr_data     = wr_data_reg;
        rd_data_out = rd_data_reg;
    end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed testbench for w5300_bus_arbiter with a small parallel-IF model.
module tb_w5300_bus_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [12*N-1:0] req_caddr;
    logic [16*N-1:0] req_wr_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [15:0]     rd_data_out;
    logic            arb_busy;
    logic [11:0]     caddr;
    logic [15:0]     wr_data;
    logic            op_status = 1'b0;
    logic [15:0]     rd_data = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    // Parallel-IF model controls and captured command
    logic        if_enable = 1'b1;
    int          if_hold   = 1;
    logic [15:0] if_rd_val = 16'h0000;
    logic        if_busy   = 1'b0;
    int          if_cnt    = 0;
    logic [11:0] cap_caddr = 12'h000;
    logic [15:0] cap_wr_data = 16'h0000;

    w5300_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(64), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .req_caddr(req_caddr), .req_wr_data(req_wr_data),
        .grant(grant), .done(done), .err(err), .rd_data_out(rd_data_out),
        .arb_busy(arb_busy), .caddr(caddr), .wr_data(wr_data),
        .op_status(op_status), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // IF model: starts on a valid caddr, holds op_status for if_hold cycles,
    // presents read data as op_status falls
    always @(posedge clk) begin
        if (if_busy) begin
            if (if_cnt <= 1) begin
                op_status <= 1'b0;
                if_busy   <= 1'b0;
                rd_data   <= if_rd_val;
            end else begin
                if_cnt <= if_cnt - 1;
            end
        end else if (if_enable && !caddr[11]) begin
            op_status   <= 1'b1;
            if_busy     <= 1'b1;
            if_cnt      <= if_hold;
            cap_caddr   <= caddr;
            cap_wr_data <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a done pulse; idx = -1 when the bound expires
    task automatic wait_done(input int limit, output int idx);
        int cycles;
        idx = -1;
        cycles = 0;
        while (idx < 0 && cycles < limit) begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < N; i++) if (done[i]) idx = i;
        end
        $display("[TB] transaction: done idx=%0d rd_data_out=%h err=%b after %0d cycles",
                 idx, rd_data_out, err, cycles);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int idx;
        int busy_cnt;
        int done_cnt;
        rst = 1'b1;
        req = '0;
        lock = '0;
        req_caddr = {N{12'h800}};
        req_wr_data = '0;
        tick(3);
        // Reset state
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data_out", rd_data_out, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_caddr", caddr, 12'h800);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b0;

        // Round robin: all four requesters high from reset, fast IF
        if_hold = 1;
        req_caddr = {12'h403, 12'h402, 12'h401, 12'h400};
        req = 4'b1111;
`ifdef W5300_ARB_INT_PRIO_EN
        for (int g = 0; g < 5; g++) begin
            wait_done(40, idx);
            chk("rr_order", idx, 0);
        end
`else
        for (int g = 0; g < 5; g++) begin
            wait_done(40, idx);
            chk("rr_order", idx, g % 4);
        end
`endif
        req = '0;
        tick(2);

        // Single read from requester 1
        if_hold = 5;
        if_rd_val = 16'h5300;
        req_caddr[23:12] = 12'h4FE;
        req[1] = 1'b1;
        tick(1);
        chk("read_caddr_latency", caddr, 12'h4FE);
        chk("read_grant", grant, 4'b0010);
        chk("read_busy", arb_busy, 1);
        wait_done(40, idx);
        chk("read_done_idx", idx, 1);
        chk("read_done_vec", done, 4'b0010);
        chk("read_rd_data_out", rd_data_out, 16'h5300);
        chk("read_cap_caddr", cap_caddr, 12'h4FE);
        req[1] = 1'b0;
        tick(1);
        chk("read_grant_idle", grant, 0);
        chk("read_done_single", done, 0);
        chk("read_rd_hold", rd_data_out, 16'h5300);
        tick(1);

        // Lock burst: requester 2 does three writes while requester 1 waits
        if_hold = 2;
        req_caddr[35:24] = 12'h220;
        req_wr_data[47:32] = 16'hA001;
        lock[2] = 1'b1;
        req[2] = 1'b1;
        wait_done(40, idx);
        chk("lock_first", idx, 2);
        chk("lock_cap_caddr", cap_caddr, 12'h220);
        chk("lock_cap_wdata1", cap_wr_data, 16'hA001);
        req_caddr[23:12] = 12'h010;
        req_wr_data[31:16] = 16'hB0B0;
        req[1] = 1'b1;
        req_wr_data[47:32] = 16'hA002;
        wait_done(40, idx);
        chk("lock_second", idx, 2);
        chk("lock_cap_wdata2", cap_wr_data, 16'hA002);
        req_wr_data[47:32] = 16'hA003;
        tick(2);
        lock[2] = 1'b0;
        wait_done(40, idx);
        chk("lock_third", idx, 2);
        chk("lock_cap_wdata3", cap_wr_data, 16'hA003);
        req[2] = 1'b0;
        wait_done(40, idx);
        chk("lock_then_other", idx, 1);
        chk("lock_other_wdata", cap_wr_data, 16'hB0B0);
        req[1] = 1'b0;
        tick(2);

        // Timeout: IF never responds
        if_enable = 1'b0;
        req_caddr[47:36] = 12'h4AB;
        req[3] = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done != 0) break;
            if (arb_busy) busy_cnt++;
        end
        chk("to_cycles", busy_cnt, 64);
        chk("to_done", done, 4'b1000);
        chk("to_err", err, 4'b1000);
        chk("to_rd_data_out", rd_data_out, 16'hFFFF);
        chk("to_caddr", caddr, 12'h800);
        req[3] = 1'b0;
        if_enable = 1'b1;
        tick(2);
        if_hold = 3;
        if_rd_val = 16'h1234;
        req_caddr[11:0] = 12'h401;
        req[0] = 1'b1;
        wait_done(40, idx);
        chk("after_to_idx", idx, 0);
        chk("after_to_err", err, 0);
        chk("after_to_rd", rd_data_out, 16'h1234);
        req[0] = 1'b0;
        tick(2);

        // Reset during BUSY
        if_hold = 20;
        if_rd_val = 16'hDEAD;
        req_caddr[35:24] = 12'h456;
        req[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (arb_busy && caddr == 12'h800 && op_status) break;
        end
        chk("rb_in_busy", {arb_busy, op_status}, 2'b11);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rb_grant", grant, 0);
        chk("rb_done", done, 0);
        chk("rb_busy", arb_busy, 0);
        chk("rb_caddr", caddr, 12'h800);
        chk("rb_rd_data_out", rd_data_out, 0);
        if_rd_val = 16'hBEEF;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (!op_status) break;
            if (arb_busy) busy_cnt++;
            if (done != 0) done_cnt++;
            @(negedge clk);
        end
        chk("rb_wait_opstatus", busy_cnt, 0);
        chk("rb_no_done", done_cnt, 0);
        if_hold = 2;
        wait_done(40, idx);
        chk("rb_new_idx", idx, 2);
        chk("rb_new_rd", rd_data_out, 16'hBEEF);
        req[2] = 1'b0;
        tick(2);

        // Interrupt requester vs. locked burst of requester 2
        if_rd_val = 16'h0C0C;
        req_caddr[35:24] = 12'h220;
        req_caddr[11:0] = 12'h402;
        lock[2] = 1'b1;
        req[2] = 1'b1;
        wait_done(40, idx);
        chk("prio_first", idx, 2);
        req[0] = 1'b1;
`ifdef W5300_ARB_INT_PRIO_EN
        wait_done(40, idx);
        chk("prio_second", idx, 0);
        req[0] = 1'b0;
        wait_done(40, idx);
        chk("prio_third", idx, 2);
        req[2] = 1'b0;
        lock[2] = 1'b0;
`else
        wait_done(40, idx);
        chk("prio_second", idx, 2);
        req[2] = 1'b0;
        lock[2] = 1'b0;
        wait_done(40, idx);
        chk("prio_third", idx, 0);
        req[0] = 1'b0;
`endif
        tick(2);
        chk("end_grant", grant, 0);
        chk("end_busy", arb_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
